// File: rtl/adc_pkg.sv
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared widths, FSM state encoding and address-bit helper
//                for the serial ADC reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_ADDR_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } adc_state_t;

    // Address goes out MSB first during SCLK cycles 3..5 (1-based).
    function automatic logic addr_din_bit(input logic [ADC_ADDR_W-1:0] addr,
                                          input logic [4:0]            cycle);
        logic bit_v;
        bit_v = 1'b0;
        case (cycle)
            5'd3:    bit_v = addr[2];
            5'd4:    bit_v = addr[1];
            5'd5:    bit_v = addr[0];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sclk_gen.sv
// ============================================================================
//  Module      : adc_sclk_gen
//  Description : SCLK divider; emits registered SCLK level plus one-clk
//                rise/fall ticks on the clk edge where SCLK toggles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sclk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_park,
    output logic o_sclk,
    output logic o_tick,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_sclk;
    logic       w_tick;

    assign w_tick      = i_run && (r_cnt == c_DIV_LAST);
    assign o_tick      = w_tick;
    assign o_rise_tick = w_tick && !r_sclk && !i_park;
    assign o_fall_tick = w_tick &&  r_sclk && !i_park;
    assign o_sclk      = r_sclk;

    // Parking keeps SCLK high on the closing tick so the frame ends idle-high.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b1;
        end else if (r_cnt == c_DIV_LAST) begin
            r_cnt <= 8'd0;
            if (!i_park) begin
                r_sclk <= ~r_sclk;
            end
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_spi_reader.sv
// ============================================================================
//  Module      : adc_spi_reader
//  Description : Continuous 16-bit SPI frame reader for a multi-channel ADC.
//                Optional macro ADC_SPI_READER_DISCARD_EN suppresses results
//                whose previous-frame address does not match their own.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [ADC_ADDR_W-1:0] i_channel,
    output logic                  o_adc_cs_n,
    output logic                  o_adc_sclk,
    output logic                  o_adc_din,
    input  logic                  i_adc_dout,
    output logic [ADC_DATA_W-1:0] o_sample_out,
    output logic [ADC_ADDR_W-1:0] o_sample_ch,
    output logic                  o_sample_valid,
    output logic                  o_busy
);

    localparam logic [7:0] c_GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] c_LAST_RISE = 5'(ADC_FRAME_BITS);

    adc_state_t                r_state;
    logic                      r_cs_n;
    logic                      r_din;
    logic                      r_busy;
    logic                      r_valid;
    logic [ADC_DATA_W-1:0]     r_sample_out;
    logic [ADC_ADDR_W-1:0]     r_sample_ch;
    logic [ADC_ADDR_W-1:0]     r_addr;
    logic [ADC_ADDR_W-1:0]     r_prev_addr;
    logic                      r_prev_ok;
    logic [ADC_FRAME_BITS-1:0] r_shift;
    logic [4:0]                r_fall_cnt;
    logic [4:0]                r_rise_cnt;
    logic [7:0]                r_gap_cnt;
    logic                      r_dout_s1;
    logic                      r_dout_s2;

    logic w_run;
    logic w_park;
    logic w_sclk;
    logic w_tick;
    logic w_rise_tick;
    logic w_fall_tick;
    logic w_unused_lead;

    assign w_run  = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
    assign w_park = (r_state == ST_SHIFT) && (r_rise_cnt == c_LAST_RISE);
    // Leading frame bits carry no data.
    assign w_unused_lead = &{1'b0, r_shift[ADC_FRAME_BITS-1:ADC_DATA_W]};

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .i_park      (w_park),
        .o_sclk      (w_sclk),
        .o_tick      (w_tick),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_s1 <= 1'b0;
            r_dout_s2 <= 1'b0;
        end else begin
            r_dout_s1 <= i_adc_dout;
            r_dout_s2 <= r_dout_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cs_n       <= 1'b1;
            r_din        <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_sample_out <= '0;
            r_sample_ch  <= '0;
            r_addr       <= '0;
            r_prev_addr  <= '0;
            r_prev_ok    <= 1'b0;
            r_shift      <= '0;
            r_fall_cnt   <= 5'd0;
            r_rise_cnt   <= 5'd0;
            r_gap_cnt    <= 8'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state    <= ST_SETUP;
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_addr     <= i_channel;
                        r_fall_cnt <= 5'd0;
                        r_rise_cnt <= 5'd0;
                        r_shift    <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_fall_tick) begin
                        r_state    <= ST_SHIFT;
                        r_fall_cnt <= 5'd1;
                        r_din      <= addr_din_bit(r_addr, 5'd1);
                    end
                end
                ST_SHIFT: begin
                    if (w_fall_tick) begin
                        r_fall_cnt <= r_fall_cnt + 5'd1;
                        r_din      <= addr_din_bit(r_addr, r_fall_cnt + 5'd1);
                    end
                    if (w_rise_tick) begin
                        r_rise_cnt <= r_rise_cnt + 5'd1;
                        r_shift    <= {r_shift[ADC_FRAME_BITS-2:0], r_dout_s2};
                    end
                    // The frame closes one half-period after the last rising edge.
                    if (w_tick && w_park) begin
                        r_state <= ST_DONE;
`ifdef ADC_SPI_READER_DISCARD_EN
                        if (r_prev_ok && (r_prev_addr == r_addr)) begin
                            r_sample_out <= r_shift[ADC_DATA_W-1:0];
                            r_sample_ch  <= r_prev_addr;
                            r_valid      <= 1'b1;
                        end
`else
                        r_sample_out <= r_shift[ADC_DATA_W-1:0];
                        r_sample_ch  <= r_prev_ok ? r_prev_addr : '0;
                        r_valid      <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_GAP;
                    r_cs_n      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_din       <= 1'b0;
                    r_gap_cnt   <= 8'd0;
                    r_prev_addr <= r_addr;
                    r_prev_ok   <= 1'b1;
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        if (i_enable) begin
                            r_state    <= ST_SETUP;
                            r_cs_n     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_addr     <= i_channel;
                            r_fall_cnt <= 5'd0;
                            r_rise_cnt <= 5'd0;
                            r_shift    <= '0;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_prev_ok <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_adc_cs_n     = r_cs_n;
    assign o_adc_sclk     = w_sclk;
    assign o_adc_din      = r_din;
    assign o_sample_out   = r_sample_out;
    assign o_sample_ch    = r_sample_ch;
    assign o_sample_valid = r_valid;
    assign o_busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
// ============================================================================
//  Module      : tb_adc_spi_reader
//  Description : Directed bench for adc_spi_reader with a behavioural ADC
//                that answers with the conversion of the previous address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_spi_reader;

`ifdef ADC_SPI_READER_DISCARD_EN
    localparam bit c_DISC = 1'b1;
`else
    localparam bit c_DISC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [2:0]  i_channel = 3'd0;
    logic        i_adc_dout = 1'b0;
    logic        o_adc_cs_n;
    logic        o_adc_sclk;
    logic        o_adc_din;
    logic [11:0] o_sample_out;
    logic [2:0]  o_sample_ch;
    logic        o_sample_valid;
    logic        o_busy;

    int tests_run = 0;
    int tests_failed = 0;

    adc_spi_reader #(
        .CLK_DIV    (4),
        .GAP_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (i_enable),
        .i_channel      (i_channel),
        .o_adc_cs_n     (o_adc_cs_n),
        .o_adc_sclk     (o_adc_sclk),
        .o_adc_din      (o_adc_din),
        .i_adc_dout     (i_adc_dout),
        .o_sample_out   (o_sample_out),
        .o_sample_ch    (o_sample_ch),
        .o_sample_valid (o_sample_valid),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    // ADC model: drives bit on SCLK fall, captures address on rises 3..5.
    logic [11:0] conv [8];
    logic [3:0]  lead;
    logic [2:0]  model_prev = 3'd0;
    logic [2:0]  addr_sh = 3'd0;
    logic [15:0] word = 16'd0;
    int          m_fall = 0;
    int          m_rise = 0;

    always @(negedge o_adc_cs_n) begin
        m_fall = 0;
        m_rise = 0;
        word   = {lead, conv[model_prev]};
    end

    always @(negedge o_adc_sclk) begin
        if (!o_adc_cs_n) begin
            m_fall = m_fall + 1;
            if (m_fall <= 16) i_adc_dout = word[16-m_fall];
        end
    end

    always @(posedge o_adc_sclk) begin
        if (!o_adc_cs_n) begin
            m_rise = m_rise + 1;
            if (m_rise >= 3 && m_rise <= 5) addr_sh = {addr_sh[1:0], o_adc_din};
        end
    end

    always @(posedge o_adc_cs_n) begin
        if (m_rise == 16) model_prev = addr_sh;
    end

    // Bus monitor sampled on the inactive clock edge.
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    int          cur_len = 0, cur_rises = 0, last_len = 0, last_rises = 0;
    logic [2:0]  cur_addr = 3'd0, last_addr = 3'd0;
    int          frames_done = 0;
    int          v_n = 0;
    logic [11:0] v_out [64];
    logic [2:0]  v_ch [64];

    always @(negedge clk) begin
        if (o_sample_valid && v_n < 64) begin
            v_out[v_n] = o_sample_out;
            v_ch[v_n]  = o_sample_ch;
            v_n = v_n + 1;
        end
        if (prev_cs && !o_adc_cs_n) begin
            cur_len = 1; cur_rises = 0; cur_addr = 3'd0;
        end else if (!o_adc_cs_n) begin
            cur_len = cur_len + 1;
            if (!prev_sclk && o_adc_sclk) begin
                cur_rises = cur_rises + 1;
                if (cur_rises >= 3 && cur_rises <= 5) cur_addr = {cur_addr[1:0], o_adc_din};
            end
        end
        if (!prev_cs && o_adc_cs_n) begin
            last_len = cur_len; last_rises = cur_rises; last_addr = cur_addr;
            if (cur_rises == 16) frames_done = frames_done + 1;
        end
        prev_cs   = o_adc_cs_n;
        prev_sclk = o_adc_sclk;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 2000) begin @(negedge clk); n++; end
        if (frames_done < target) begin
            tests_run++; tests_failed++;
            $display("FAIL frame_timeout frames=%0d required=%0d", frames_done, target);
        end
    endtask

    task automatic wait_cs_low();
        int n = 0;
        while (o_adc_cs_n && n < 2000) begin @(negedge clk); n++; end
        if (o_adc_cs_n) begin
            tests_run++; tests_failed++;
            $display("FAIL cs_low_timeout cs_n=%b required=0", o_adc_cs_n);
        end
    endtask

    task automatic wait_rises(input int k);
        int n = 0;
        while (!(!o_adc_cs_n && cur_rises >= k) && n < 2000) begin @(negedge clk); n++; end
        if (cur_rises < k) begin
            tests_run++; tests_failed++;
            $display("FAIL rise_timeout rises=%0d required=%0d", cur_rises, k);
        end
    endtask

    // Runs n frames; chv holds up to four 3-bit channels, first in [11:9].
    task automatic run_seq(input int n, input logic [11:0] chv);
        int base;
        base = frames_done;
        @(negedge clk);
        i_channel = chv[11:9];
        i_enable  = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) i_channel = chv[11-3*k -: 3];
            if (k == n-1) begin wait_cs_low(); i_enable = 1'b0; end
            wait_frames(base + k + 1);
        end
        idle(20);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        tests_run += 7;
        if (o_adc_cs_n !== 1'b1)     begin tests_failed++; $display("FAIL rst_cs_n got=%b exp=1", o_adc_cs_n); end
        if (o_adc_sclk !== 1'b1)     begin tests_failed++; $display("FAIL rst_sclk got=%b exp=1", o_adc_sclk); end
        if (o_adc_din !== 1'b0)      begin tests_failed++; $display("FAIL rst_din got=%b exp=0", o_adc_din); end
        if (o_sample_out !== 12'h0)  begin tests_failed++; $display("FAIL rst_out got=%h exp=000", o_sample_out); end
        if (o_sample_ch !== 3'd0)    begin tests_failed++; $display("FAIL rst_ch got=%0d exp=0", o_sample_ch); end
        if (o_sample_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got=%b exp=0", o_sample_valid); end
        if (o_busy !== 1'b0)         begin tests_failed++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_channel();
        int vb, en;
        logic [11:0] eo [2];
        logic [2:0]  ec [2];
        vb = v_n;
        if (c_DISC) begin en = 1; eo[0] = 12'hABC; ec[0] = 3'd2; end
        else begin en = 2; eo[0] = 12'h123; ec[0] = 3'd0; eo[1] = 12'hABC; ec[1] = 3'd2; end
        run_seq(2, {3'd2, 3'd2, 6'd0});
        tests_run++;
        if (v_n - vb !== en) begin tests_failed++; $display("FAIL single_valid_cnt got=%0d exp=%0d", v_n - vb, en); end
        for (int i = 0; i < en && vb + i < v_n; i++) begin
            tests_run += 2;
            if (v_out[vb+i] !== eo[i]) begin tests_failed++; $display("FAIL single_out[%0d] got=%h exp=%h", i, v_out[vb+i], eo[i]); end
            if (v_ch[vb+i] !== ec[i])  begin tests_failed++; $display("FAIL single_ch[%0d] got=%0d exp=%0d", i, v_ch[vb+i], ec[i]); end
        end
    endtask

    task automatic test_frame_timing();
        int n;
        bit busy_seen;
        @(negedge clk);
        i_channel = 3'd5;
        i_enable  = 1'b1;
        wait_cs_low();
        i_enable  = 1'b0;
        wait_rises(6);
        busy_seen = o_busy;
        wait_frames(frames_done + 1);
        n = 0;
        tests_run += 5;
        if (busy_seen !== 1'b1)  begin tests_failed++; $display("FAIL timing_busy_mid got=%b exp=1", busy_seen); end
        if (o_busy !== 1'b0)     begin tests_failed++; $display("FAIL timing_busy_after got=%b exp=0", o_busy); end
        if (last_len !== 133)    begin tests_failed++; $display("FAIL timing_cs_low got=%0d exp=133", last_len); end
        if (last_rises !== 16)   begin tests_failed++; $display("FAIL timing_rises got=%0d exp=16", last_rises); end
        if (last_addr !== 3'd5)  begin tests_failed++; $display("FAIL timing_din_addr got=%0d exp=5", last_addr); end
        idle(20);
    endtask

    task automatic test_channel_seq();
        int vb, en;
        logic [11:0] eo [4];
        logic [2:0]  ec [4];
        vb = v_n;
        if (c_DISC) begin
            en = 2;
            eo[0] = 12'h456; ec[0] = 3'd1;
            eo[1] = 12'h5A5; ec[1] = 3'd5;
        end else begin
            en = 4;
            eo[0] = 12'h5A5; ec[0] = 3'd0;
            eo[1] = 12'h456; ec[1] = 3'd1;
            eo[2] = 12'h456; ec[2] = 3'd1;
            eo[3] = 12'h5A5; ec[3] = 3'd5;
        end
        run_seq(4, {3'd1, 3'd1, 3'd5, 3'd5});
        tests_run++;
        if (v_n - vb !== en) begin tests_failed++; $display("FAIL seq_valid_cnt got=%0d exp=%0d", v_n - vb, en); end
        for (int i = 0; i < en && vb + i < v_n; i++) begin
            tests_run += 2;
            if (v_out[vb+i] !== eo[i]) begin tests_failed++; $display("FAIL seq_out[%0d] got=%h exp=%h", i, v_out[vb+i], eo[i]); end
            if (v_ch[vb+i] !== ec[i])  begin tests_failed++; $display("FAIL seq_ch[%0d] got=%0d exp=%0d", i, v_ch[vb+i], ec[i]); end
        end
    endtask

    task automatic test_enable_drop();
        int vb, fb, en;
        vb = v_n;
        fb = frames_done;
        en = c_DISC ? 0 : 1;
        @(negedge clk);
        i_channel = 3'd3;
        i_enable  = 1'b1;
        wait_rises(8);
        i_enable  = 1'b0;
        wait_frames(fb + 1);
        idle(40);
        tests_run += 5;
        if (v_n - vb !== en)        begin tests_failed++; $display("FAIL drop_valid_cnt got=%0d exp=%0d", v_n - vb, en); end
        if (o_adc_cs_n !== 1'b1)    begin tests_failed++; $display("FAIL drop_cs_n got=%b exp=1", o_adc_cs_n); end
        if (o_busy !== 1'b0)        begin tests_failed++; $display("FAIL drop_busy got=%b exp=0", o_busy); end
        if (frames_done !== fb + 1) begin tests_failed++; $display("FAIL drop_frames got=%0d exp=%0d", frames_done, fb + 1); end
        if (last_addr !== 3'd3)     begin tests_failed++; $display("FAIL drop_din_addr got=%0d exp=3", last_addr); end
        for (int i = 0; i < en && vb + i < v_n; i++) begin
            tests_run += 2;
            if (v_out[vb+i] !== 12'h5A5) begin tests_failed++; $display("FAIL drop_out got=%h exp=5a5", v_out[vb+i]); end
            if (v_ch[vb+i] !== 3'd0)     begin tests_failed++; $display("FAIL drop_ch got=%0d exp=0", v_ch[vb+i]); end
        end
    endtask

    task automatic test_reset_mid();
        int vb;
        @(negedge clk);
        i_channel = 3'd4;
        i_enable  = 1'b1;
        wait_rises(10);
        vb  = v_n;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run += 6;
        if (o_adc_cs_n !== 1'b1)     begin tests_failed++; $display("FAIL mid_rst_cs_n got=%b exp=1", o_adc_cs_n); end
        if (o_adc_sclk !== 1'b1)     begin tests_failed++; $display("FAIL mid_rst_sclk got=%b exp=1", o_adc_sclk); end
        if (o_sample_out !== 12'h0)  begin tests_failed++; $display("FAIL mid_rst_out got=%h exp=000", o_sample_out); end
        if (o_sample_ch !== 3'd0)    begin tests_failed++; $display("FAIL mid_rst_ch got=%0d exp=0", o_sample_ch); end
        if (o_sample_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got=%b exp=0", o_sample_valid); end
        if (o_busy !== 1'b0)         begin tests_failed++; $display("FAIL mid_rst_busy got=%b exp=0", o_busy); end
        @(negedge clk);
        rst      = 1'b0;
        i_enable = 1'b0;
        idle(20);
        tests_run++;
        if (v_n !== vb) begin tests_failed++; $display("FAIL mid_rst_no_valid got=%0d exp=%0d", v_n, vb); end
        vb = v_n;
        run_seq(2, {3'd2, 3'd2, 6'd0});
        tests_run += 3;
        if (v_n - vb !== (c_DISC ? 1 : 2)) begin tests_failed++; $display("FAIL restart_valid_cnt got=%0d exp=%0d", v_n - vb, c_DISC ? 1 : 2); end
        if (v_out[v_n-1] !== 12'hABC) begin tests_failed++; $display("FAIL restart_out got=%h exp=abc", v_out[v_n-1]); end
        if (v_ch[v_n-1] !== 3'd2)     begin tests_failed++; $display("FAIL restart_ch got=%0d exp=2", v_ch[v_n-1]); end
    endtask

    task automatic test_extremes();
        int vb, en;
        logic [11:0] eo [4];
        logic [2:0]  ec [4];
        lead = 4'hF;
        vb = v_n;
        if (c_DISC) begin
            en = 2;
            eo[0] = 12'h000; ec[0] = 3'd6;
            eo[1] = 12'hFFF; ec[1] = 3'd7;
        end else begin
            en = 4;
            eo[0] = 12'hABC; ec[0] = 3'd0;
            eo[1] = 12'h000; ec[1] = 3'd6;
            eo[2] = 12'h000; ec[2] = 3'd6;
            eo[3] = 12'hFFF; ec[3] = 3'd7;
        end
        run_seq(4, {3'd6, 3'd6, 3'd7, 3'd7});
        tests_run++;
        if (v_n - vb !== en) begin tests_failed++; $display("FAIL ext_valid_cnt got=%0d exp=%0d", v_n - vb, en); end
        for (int i = 0; i < en && vb + i < v_n; i++) begin
            tests_run += 2;
            if (v_out[vb+i] !== eo[i]) begin tests_failed++; $display("FAIL ext_out[%0d] got=%h exp=%h", i, v_out[vb+i], eo[i]); end
            if (v_ch[vb+i] !== ec[i])  begin tests_failed++; $display("FAIL ext_ch[%0d] got=%0d exp=%0d", i, v_ch[vb+i], ec[i]); end
        end
    endtask

    initial begin
        conv[0] = 12'h123; conv[1] = 12'h456; conv[2] = 12'hABC; conv[3] = 12'h3C3;
        conv[4] = 12'h777; conv[5] = 12'h5A5; conv[6] = 12'h000; conv[7] = 12'hFFF;
        lead = 4'h0;
        test_reset();
        test_single_channel();
        test_frame_timing();
        test_channel_seq();
        test_enable_drop();
        test_reset_mid();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
